mux_arb_2x4b: RTL

Two-requester round-robin arbiter that shares a single `mux2x1_4b` 4-bit datapath between requesters A and B. It chooses the requester, drives the mux select, and registers the selected nibble into a one-entry output stage with a valid/ready handshake toward the ALU operand path. Per-requester grant counters support fairness checks.

---
 rtl/mux_arb_2x4b_pkg.sv | 15 +
 rtl/mux_arb_2x4b_mux.sv | 11 +
 rtl/mux_arb_2x4b.sv | 92 +++++++++
 3 files changed

// File: rtl/mux_arb_2x4b_pkg.sv
// Shared constants for the two-requester nibble arbiter: source codes,
// FSM state encoding and the default grant-counter width.
package mux_arb_2x4b_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_arb_2x4b_mux.sv
// 2:1 nibble multiplexer shared by the arbiter datapath; sel=0 picks a.
module mux2x1_4b (
  output logic [3:0] out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sel
);

  assign out = sel ? b : a;

endmodule

// File: rtl/mux_arb_2x4b.sv
// Round-robin arbiter between requesters A and B feeding a one-entry
// registered output stage with valid/ready, plus per-requester grant counters.
//
// state    | meaning
// ST_EMPTY | output stage holds nothing, out_valid=0
// ST_FULL  | output stage holds an unconsumed nibble, out_valid=1
module mux_arb_2x4b
  import mux_arb_2x4b_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [3:0]       data_a,
  input  logic             req_b,
  input  logic [3:0]       data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [3:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic       last_sel;
  logic       sel;
  logic       slot_free;
  logic       capture;
  logic [3:0] mux_out;

  mux2x1_4b u_mux (
    .out (mux_out),
    .a   (data_a),
    .b   (data_b),
    .sel (sel)
  );

  always_comb begin
    sel = SRC_A;
    if (req_a && req_b) begin
      sel = ~last_sel;
    end else if (req_b) begin
      sel = SRC_B;
    end

    slot_free = (state == ST_EMPTY) || out_ready;
    // Reset suppresses the grant so no nibble is acknowledged and then lost.
    capture   = !reset && slot_free && (req_a || req_b);
    ack_a     = capture && (sel == SRC_A);
    ack_b     = capture && (sel == SRC_B);

    state_nxt = state;
    if (capture) begin
      state_nxt = ST_FULL;
    end else if ((state == ST_FULL) && out_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      out      <= 4'h0;
      out_src  <= SRC_A;
      last_sel <= SRC_B;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        out      <= mux_out;
        out_src  <= sel;
        last_sel <= sel;
        if (sel == SRC_B) begin
          cnt_b <= cnt_b + CNT_ONE;
        end else begin
          cnt_a <= cnt_a + CNT_ONE;
        end
      end
    end
  end

endmodule
